up_down_mod_counter: RTL and testbench

UP_DOWN_MOD_COUNTER -- requirements
Module: up_down_mod_counter

---
 rtl/udc_pkg.sv | 16 +
 rtl/udc_next_value.sv | 48 ++++
 rtl/up_down_mod_counter.sv | 59 +++++
 tb/tb_up_down_mod_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared constants for the up/down modulo counter: count direction encoding and default geometry.
// Used by up_down_mod_counter and udc_next_value.
package udc_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH   = 3;
    localparam int DEFAULT_MODULUS = 8;

    // True when a modulus fits the legal range for a given register width.
    function automatic bit modulusLegal(input int width, input int modulus);
        return (modulus >= 2) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/udc_next_value.sv
// Combinational next-state logic for the up/down modulo counter: load clamp, count, wrap detection.
// Build option UDC_SATURATE_EN: hold at the count bounds instead of wrapping (wrap_o then flags the blocked attempt).
module udc_next_value
    import udc_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             m_i,
    input  logic             en_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             wrap_o
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_MIN   = '0;

    logic atBound;

    // Using >= for the upper bound keeps any out-of-range value heading back into range.
    assign atBound = (m_i == DIR_UP) ? (q_i >= Q_MAX) : (q_i == Q_MIN);

    always_comb begin
        q_next_o = q_i;
        wrap_o   = 1'b0;
        if (ld_i) begin
            q_next_o = ({1'b0, d_i} < MOD_EXT) ? d_i : Q_MAX;
        end else if (en_i) begin
            if (atBound) begin
                wrap_o = 1'b1;
`ifdef UDC_SATURATE_EN
                q_next_o = q_i;
`else
                q_next_o = (m_i == DIR_UP) ? Q_MIN : Q_MAX;
`endif
            end else if (m_i == DIR_UP) begin
                q_next_o = q_i + WIDTH'(1);
            end else begin
                q_next_o = q_i - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/up_down_mod_counter.sv
// Up/down modulo-MODULUS counter with clamped parallel load, terminal-count decode and registered carry/borrow.
// Build option UDC_SATURATE_EN (handled in udc_next_value) turns wrapping into saturation.
module up_down_mod_counter
    import udc_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             M,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CO
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    if (!modulusLegal(WIDTH, MODULUS)) begin : gBadModulus
        $error("up_down_mod_counter: MODULUS %0d outside 2..2**WIDTH for WIDTH %0d", MODULUS, WIDTH);
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             co_q;
    logic             co_d;

    udc_next_value #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q_i      (q_q),
        .m_i      (M),
        .en_i     (EN),
        .ld_i     (LD),
        .d_i      (D),
        .q_next_o (q_d),
        .wrap_o   (co_d)
    );

    // Clear takes priority over load and count, so an interrupted wrap never produces a carry.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q  <= '0;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            co_q <= co_d;
        end
    end

    assign Q  = q_q;
    assign CO = co_q;
    assign TC = (M == DIR_UP) ? (q_q == Q_MAX) : (q_q == '0);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Directed self-checking bench for up_down_mod_counter at WIDTH=3, MODULUS=6.
// Expectations follow the wrap build, or the saturating build when UDC_SATURATE_EN is defined.
module tb_up_down_mod_counter;

    logic       clk;
    logic       clr;
    logic       en;
    logic       m;
    logic       ld;
    logic [2:0] d;
    logic [2:0] q;
    logic       tc;
    logic       co;

    int compCount = 0;
    int errCount  = 0;

    up_down_mod_counter #(
        .WIDTH   (3),
        .MODULUS (6)
    ) dut (
        .CLK (clk),
        .CLR (clr),
        .EN  (en),
        .M   (m),
        .LD  (ld),
        .D   (d),
        .Q   (q),
        .TC  (tc),
        .CO  (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs, then advance past the next rising edge.
    task automatic applyStimulus(input logic c, input logic l, input logic e, input logic dir, input logic [2:0] val);
        clr = c;
        ld  = l;
        en  = e;
        m   = dir;
        d   = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] upQ  [7];
        logic       upCo [7];
        logic       upTc [7];
        upQ  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        upCo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        upTc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        clr = 1'b0; ld = 1'b0; en = 1'b0; m = 1'b0; d = '0;
        @(negedge clk);

        applyStimulus(1, 1, 1, 1, 3'd5);
        checkOutput("reset_q", 8'(q), 8'd0);
        checkOutput("reset_co", 8'(co), 8'd0);
        checkOutput("reset_tc_up", 8'(tc), 8'd0);

        applyStimulus(0, 1, 0, 0, 3'd7);
        checkOutput("load_clamp7_q", 8'(q), 8'd5);
        checkOutput("load_clamp7_co", 8'(co), 8'd0);
        applyStimulus(0, 1, 0, 0, 3'd6);
        checkOutput("load_clamp6_q", 8'(q), 8'd5);
        applyStimulus(0, 1, 1, 1, 3'd3);
        checkOutput("load_over_en_q", 8'(q), 8'd3);
        checkOutput("load_over_en_co", 8'(co), 8'd0);

        applyStimulus(0, 1, 0, 0, 3'd4);
        checkOutput("load4_q", 8'(q), 8'd4);
        applyStimulus(0, 0, 1, 1, 3'd0);
        checkOutput("mtoggle1_q", 8'(q), 8'd5);
        checkOutput("mtoggle1_tc", 8'(tc), 8'd1);
        m = 1'b0;
        #1;
        checkOutput("tc_mid_cycle_down", 8'(tc), 8'd0);
        checkOutput("q_stable_mid_cycle", 8'(q), 8'd5);
        applyStimulus(0, 0, 1, 0, 3'd0);
        checkOutput("mtoggle2_q", 8'(q), 8'd4);
        checkOutput("mtoggle2_tc", 8'(tc), 8'd0);
        applyStimulus(0, 0, 1, 1, 3'd0);
        checkOutput("mtoggle3_q", 8'(q), 8'd5);
        checkOutput("mtoggle3_tc", 8'(tc), 8'd1);

        applyStimulus(0, 0, 0, 1, 3'd0);
        checkOutput("hold_q", 8'(q), 8'd5);
        checkOutput("hold_co", 8'(co), 8'd0);

        applyStimulus(1, 0, 1, 1, 3'd0);
        checkOutput("clr_abort_q", 8'(q), 8'd0);
        checkOutput("clr_abort_co", 8'(co), 8'd0);

`ifdef UDC_SATURATE_EN
        applyStimulus(0, 1, 0, 1, 3'd5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 3'd0);
            checkOutput($sformatf("sat_up%0d_q", i), 8'(q), 8'd5);
            checkOutput($sformatf("sat_up%0d_co", i), 8'(co), 8'd1);
        end
        applyStimulus(0, 0, 1, 0, 3'd0);
        checkOutput("sat_down_q", 8'(q), 8'd4);
        checkOutput("sat_down_co", 8'(co), 8'd0);

        applyStimulus(1, 0, 0, 0, 3'd0);
        checkOutput("clr_tc_down", 8'(tc), 8'd1);
        applyStimulus(0, 0, 1, 0, 3'd0);
        checkOutput("sat_low_q", 8'(q), 8'd0);
        checkOutput("sat_low_co", 8'(co), 8'd1);
        applyStimulus(0, 0, 0, 0, 3'd0);
        checkOutput("sat_hold_co", 8'(co), 8'd0);
`else
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 1, 1, 3'd0);
            checkOutput($sformatf("up%0d_q", i), 8'(q), 8'(upQ[i]));
            checkOutput($sformatf("up%0d_co", i), 8'(co), 8'(upCo[i]));
            if (i == 4) begin
                checkOutput("up4_tc_before_wrap", 8'(tc), 8'(upTc[i]));
            end else begin
                checkOutput($sformatf("up%0d_tc", i), 8'(tc), 8'(upTc[i]));
            end
        end

        applyStimulus(1, 0, 0, 0, 3'd0);
        checkOutput("clr2_q", 8'(q), 8'd0);
        checkOutput("clr_tc_down", 8'(tc), 8'd1);
        applyStimulus(0, 0, 1, 0, 3'd0);
        checkOutput("down_wrap_q", 8'(q), 8'd5);
        checkOutput("down_wrap_co", 8'(co), 8'd1);
        applyStimulus(0, 0, 1, 0, 3'd0);
        checkOutput("down1_q", 8'(q), 8'd4);
        checkOutput("down1_co", 8'(co), 8'd0);
        applyStimulus(0, 0, 1, 0, 3'd0);
        checkOutput("down2_q", 8'(q), 8'd3);
        checkOutput("down2_co", 8'(co), 8'd0);

        applyStimulus(0, 1, 0, 1, 3'd5);
        applyStimulus(0, 0, 1, 1, 3'd0);
        checkOutput("wrap_then_q", 8'(q), 8'd0);
        checkOutput("wrap_then_co", 8'(co), 8'd1);
        applyStimulus(0, 0, 0, 1, 3'd0);
        checkOutput("wrap_hold_q", 8'(q), 8'd0);
        checkOutput("wrap_hold_co", 8'(co), 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
